// File: rtl/program_loader_if.sv
// Byte-stream and memory-port bundle of the boot loader.
// The loader is the slave of the stream and drives the memory port.
interface program_loader_if #(
    parameter int ADDR_WIDTH = 8
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [15:0]           mem_data;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  rw;

    modport slave (
        input  rx_data, rx_valid,
        output rx_ready, mem_data, mem_addr, rw
    );

    modport master (
        output rx_data, rx_valid,
        input  rx_ready, mem_data, mem_addr, rw
    );
endinterface

// File: rtl/program_loader.sv
// Boot-time loader: assembles a byte stream into 16-bit words, writes them to
// main memory, verifies an XOR checksum and then releases the processor.
module program_loader #(
    parameter int                    ADDR_WIDTH = 8,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                clk,
    input  logic                reset,
    program_loader_if.slave     bus,
    output logic                cpu_reset,
    output logic                done,
    output logic                error
);

    typedef enum logic [2:0] {
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                state, state_n;
    logic [8:0]            remaining, remaining_n;
    logic [7:0]            chk, chk_n;
    logic [7:0]            hi, hi_n;
    logic [15:0]           data_q, data_n;
    logic [ADDR_WIDTH-1:0] addr_q, addr_n;
    logic                  cpu_reset_n, done_n, error_n;
    logic                  xfer;

    // Handshake and strobe are pure decodes of the registered state.
    assign bus.rx_ready = (state == S_COUNT) || (state == S_HI) ||
                          (state == S_LO)    || (state == S_CHECK);
    assign bus.rw       = (state != S_WRITE);
    assign bus.mem_data = data_q;
    assign bus.mem_addr = addr_q;
    assign xfer         = bus.rx_valid && bus.rx_ready;

    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latch).
        state_n     = state;
        remaining_n = remaining;
        chk_n       = chk;
        hi_n        = hi;
        data_n      = data_q;
        addr_n      = addr_q;
        cpu_reset_n = cpu_reset;
        done_n      = done;
        error_n     = error;

        unique case (state)
            S_COUNT: if (xfer) begin
                remaining_n = (bus.rx_data == 8'h00) ? 9'd256 : {1'b0, bus.rx_data};
                chk_n       = bus.rx_data;
                state_n     = S_HI;
            end
            S_HI: if (xfer) begin
                hi_n    = bus.rx_data;
                chk_n   = chk ^ bus.rx_data;
                state_n = S_LO;
            end
            S_LO: if (xfer) begin
                data_n  = {hi, bus.rx_data};
                chk_n   = chk ^ bus.rx_data;
                state_n = S_WRITE;
            end
            S_WRITE: begin
                addr_n      = addr_q + ADDR_WIDTH'(1);
                remaining_n = remaining - 9'd1;
                state_n     = (remaining == 9'd1) ? S_CHECK : S_HI;
            end
            S_CHECK: if (xfer) begin
                if (bus.rx_data == chk) begin
                    state_n     = S_DONE;
                    done_n      = 1'b1;
                    cpu_reset_n = 1'b0;
                end else begin
                    state_n = S_ERROR;
                    error_n = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_COUNT;
            remaining <= 9'd0;
            chk       <= 8'h00;
            hi        <= 8'h00;
            data_q    <= 16'h0000;
            addr_q    <= BASE_ADDR;
            cpu_reset <= 1'b1;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            chk       <= chk_n;
            hi        <= hi_n;
            data_q    <= data_n;
            addr_q    <= addr_n;
            cpu_reset <= cpu_reset_n;
            done      <= done_n;
            error     <= error_n;
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: cycle vector table plus directed
// sequences for backpressure, full-depth load and reset mid-load.
module tb_program_loader;

    logic clk = 1'b0;
    logic reset;
    logic cpu_reset, done, error;

    always #5 clk = ~clk;

    program_loader_if #(.ADDR_WIDTH(8)) bus ();

    program_loader #(.ADDR_WIDTH(8), .BASE_ADDR(8'h00)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
        .cpu_reset (cpu_reset),
        .done      (done),
        .error     (error)
    );

    // Main memory model and write monitor.
    logic [15:0] mem [256];
    int          wr_count = 0;
    logic [7:0]  last_wr_addr = 8'h00;

    always @(posedge clk) begin
        if (bus.rw === 1'b0) begin
            mem[bus.mem_addr] = bus.mem_data;
            last_wr_addr      = bus.mem_addr;
            wr_count          = wr_count + 1;
        end
    end

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // {rx_ready, rw, cpu_reset, done, error, mem_addr, mem_data}
    function automatic logic [31:0] pk(input logic r, input logic w, input logic c,
                                       input logic d, input logic e,
                                       input logic [7:0] a, input logic [15:0] dat);
        return {3'b000, r, w, c, d, e, a, dat};
    endfunction

    function automatic logic [31:0] obs();
        return pk(bus.rx_ready, bus.rw, cpu_reset, done, error, bus.mem_addr, bus.mem_data);
    endfunction

    typedef struct {
        logic        rst;
        logic [7:0]  d;
        logic        v;
        logic [31:0] exp;
    } vec_t;

    vec_t tv[$];

    task automatic do_reset(input int cycles);
        @(negedge clk);
        reset        = 1'b1;
        bus.rx_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Offer one byte with random gaps; bounded wait for the transfer.
    task automatic send(input logic [7:0] b, input int gap_pct);
        int t = 0;
        bit sent = 1'b0;
        while (!sent && t < 200) begin
            @(negedge clk);
            bus.rx_data  = b;
            bus.rx_valid = ($urandom_range(99) >= gap_pct);
            if (bus.rx_valid && bus.rx_ready) sent = 1'b1;
            @(posedge clk);
            t++;
        end
        if (!sent) check("send_timeout", 32'(sent), 32'd1);
    endtask

    task automatic wait_end();
        int t = 0;
        @(negedge clk);
        bus.rx_valid = 1'b0;
        while (!(done || error) && t < 20) begin
            @(negedge clk);
            t++;
        end
    endtask

    int base;

    initial begin
        reset        = 1'b1;
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Nominal load; the AB and 42 bytes are held valid across WRITE.
        tv.push_back('{1'b0, 8'h02, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'h12, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'h34, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'hAB, 1'b1, pk(0, 0, 1, 0, 0, 8'h00, 16'h1234)});
        tv.push_back('{1'b0, 8'hAB, 1'b1, pk(1, 1, 1, 0, 0, 8'h01, 16'h1234)});
        tv.push_back('{1'b0, 8'hCD, 1'b1, pk(1, 1, 1, 0, 0, 8'h01, 16'h1234)});
        tv.push_back('{1'b0, 8'h42, 1'b1, pk(0, 0, 1, 0, 0, 8'h01, 16'hABCD)});
        tv.push_back('{1'b0, 8'h42, 1'b1, pk(1, 1, 1, 0, 0, 8'h02, 16'hABCD)});
        tv.push_back('{1'b0, 8'h55, 1'b1, pk(0, 1, 0, 1, 0, 8'h02, 16'hABCD)});
        tv.push_back('{1'b0, 8'h55, 1'b1, pk(0, 1, 0, 1, 0, 8'h02, 16'hABCD)});
        tv.push_back('{1'b1, 8'h00, 1'b0, pk(0, 1, 0, 1, 0, 8'h02, 16'hABCD)});
        // Bad checksum: same stream ending in 43.
        tv.push_back('{1'b0, 8'h02, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'h12, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'h34, 1'b1, pk(1, 1, 1, 0, 0, 8'h00, 16'h0000)});
        tv.push_back('{1'b0, 8'hAB, 1'b1, pk(0, 0, 1, 0, 0, 8'h00, 16'h1234)});
        tv.push_back('{1'b0, 8'hAB, 1'b1, pk(1, 1, 1, 0, 0, 8'h01, 16'h1234)});
        tv.push_back('{1'b0, 8'hCD, 1'b1, pk(1, 1, 1, 0, 0, 8'h01, 16'h1234)});
        tv.push_back('{1'b0, 8'h43, 1'b1, pk(0, 0, 1, 0, 0, 8'h01, 16'hABCD)});
        tv.push_back('{1'b0, 8'h43, 1'b1, pk(1, 1, 1, 0, 0, 8'h02, 16'hABCD)});
        tv.push_back('{1'b0, 8'h55, 1'b1, pk(0, 1, 1, 0, 1, 8'h02, 16'hABCD)});
        tv.push_back('{1'b0, 8'h55, 1'b1, pk(0, 1, 1, 0, 1, 8'h02, 16'hABCD)});

        // Reset with random inputs.
        repeat (2) begin
            @(negedge clk);
            reset        = 1'b1;
            bus.rx_data  = 8'($urandom);
            bus.rx_valid = 1'($urandom);
            @(posedge clk);
        end
        @(negedge clk);
        reset        = 1'b0;
        bus.rx_valid = 1'b0;
        check("reset", obs(), pk(1, 1, 1, 0, 0, 8'h00, 16'h0000));

        // Vector table.
        base = wr_count;
        for (int i = 0; i < tv.size(); i++) begin
            @(negedge clk);
            reset        = tv[i].rst;
            bus.rx_data  = tv[i].d;
            bus.rx_valid = tv[i].v;
            check($sformatf("vec%0d", i), obs(), tv[i].exp);
        end
        @(negedge clk);
        bus.rx_valid = 1'b0;
        check("table_writes", 32'(wr_count - base), 32'd4);
        check("table_mem0", 32'(mem[0]), 32'h1234);
        check("table_mem1", 32'(mem[1]), 32'hABCD);

        // Backpressure: 02 5A A5 0F F0, checksum 02.
        do_reset(1);
        base = wr_count;
        send(8'h02, 40); send(8'h5A, 40); send(8'hA5, 40);
        send(8'h0F, 40); send(8'hF0, 40); send(8'h02, 40);
        wait_end();
        check("bp_writes", 32'(wr_count - base), 32'd2);
        check("bp_mem0", 32'(mem[0]), 32'h5AA5);
        check("bp_mem1", 32'(mem[1]), 32'h0FF0);
        check("bp_status", {29'd0, cpu_reset, done, error}, 32'b010);

        // Full depth: 256 words of addr*0x0101; checksum is 0x00.
        do_reset(1);
        base = wr_count;
        send(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            send(8'(i), 0);
            send(8'(i), 0);
        end
        send(8'h00, 0);
        wait_end();
        check("full_writes", 32'(wr_count - base), 32'd256);
        check("full_last_addr", 32'(last_wr_addr), 32'h00FF);
        check("full_addr_wrap", 32'(bus.mem_addr), 32'h0000);
        check("full_done", {29'd0, cpu_reset, done, error}, 32'b010);
        check("full_mem80", 32'(mem[8'h80]), 32'h8080);
        check("full_memff", 32'(mem[8'hFF]), 32'hFFFF);

        // Reset mid-load after 02 12 34 AB.
        do_reset(1);
        base = wr_count;
        send(8'h02, 0); send(8'h12, 0); send(8'h34, 0); send(8'hAB, 0);
        do_reset(1);
        check("mid_writes", 32'(wr_count - base), 32'd1);
        check("mid_mem0", 32'(mem[0]), 32'h1234);
        check("mid_state", obs(), pk(1, 1, 1, 0, 0, 8'h00, 16'h0000));
        send(8'h01, 0); send(8'hBE, 0); send(8'hEF, 0); send(8'h50, 0);
        wait_end();
        check("mid_reload_mem0", 32'(mem[0]), 32'hBEEF);
        check("mid_reload_writes", 32'(wr_count - base), 32'd2);
        check("mid_reload_done", {29'd0, cpu_reset, done, error}, 32'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
